// File: rtl/barrel_thread_sched.sv
// Per-cycle barrel thread scheduler: round-robin issue among enabled threads
// with a per-thread cooldown so a thread never re-issues before its previous
// instruction has cleared the dependent pipeline stages.
module barrel_thread_sched #(
  parameter int unsigned NUM_THREADS = 8,
  parameter int unsigned MIN_GAP     = 5,
  parameter int unsigned CNT_WIDTH   = 4,
  localparam int unsigned BITS_THREADS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_THREADS-1:0]  thread_en,
  input  logic                    mem_busy,
  input  logic                    block_valid,
  input  logic [BITS_THREADS-1:0] block_tid,
  input  logic [CNT_WIDTH-1:0]    block_cycles,
  output logic                    issue_valid,
  output logic [BITS_THREADS-1:0] issue_tid,
  output logic                    pl_stall,
  output logic                    pl_flush_fd,
  output logic                    all_idle
);

  localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(MIN_GAP - 1);

  logic [CNT_WIDTH-1:0]    cd_q [NUM_THREADS];
  logic [CNT_WIDTH-1:0]    cd_d [NUM_THREADS];
  logic [BITS_THREADS-1:0] rr_q, rr_d;
  logic                    valid_d;
  logic [BITS_THREADS-1:0] tid_d;
  logic [NUM_THREADS-1:0]  elig;
  logic                    win_found;
  logic [BITS_THREADS-1:0] win_tid;
  logic                    block_hit;

  // A thread may issue when enabled and its cooldown has expired
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      elig[t] = thread_en[t] && (cd_q[t] == '0);
    end
  end

  // Round-robin pick: scan backwards so the first eligible from rr_q wins
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_tid   = '0;
    idx       = 0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      idx = 32'(rr_q) + 32'(i);
      if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
      if (elig[idx]) begin
        win_found = 1'b1;
        win_tid   = BITS_THREADS'(idx);
      end
    end
  end

  assign block_hit = block_valid && (32'(block_tid) < NUM_THREADS);

  // Next-state: issue registers, pointer and cooldowns; block loads bypass stall
  always_comb begin
    valid_d = issue_valid;
    tid_d   = issue_tid;
    rr_d    = rr_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      cd_d[t] = cd_q[t];
    end

    if (!mem_busy) begin
      valid_d = win_found;
      if (win_found) begin
        tid_d = win_tid;
        rr_d  = (32'(win_tid) == NUM_THREADS - 1) ? '0 : BITS_THREADS'(win_tid + 1'b1);
      end
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (win_found && (32'(win_tid) == 32'(t))) begin
          cd_d[t] = RELOAD;
        end else if (cd_q[t] != '0) begin
          cd_d[t] = cd_q[t] - 1'b1;
        end
      end
    end

    if (block_hit) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (32'(block_tid) == 32'(t)) begin
          if (!mem_busy && win_found && (win_tid == block_tid)) begin
            cd_d[t] = (block_cycles > RELOAD) ? block_cycles : RELOAD;
          end else begin
            cd_d[t] = (block_cycles > cd_q[t]) ? block_cycles : cd_q[t];
          end
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_tid   <= '0;
      rr_q        <= '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        cd_q[t] <= '0;
      end
    end else begin
      issue_valid <= valid_d;
      issue_tid   <= tid_d;
      rr_q        <= rr_d;
      for (int t = 0; t < NUM_THREADS; t++) begin
        cd_q[t] <= cd_d[t];
      end
    end
  end

  assign pl_stall    = mem_busy;
  assign pl_flush_fd = !issue_valid && !mem_busy;
  assign all_idle    = ~|thread_en;

endmodule
